// File: rtl/pbit_sample_decoder.sv
// Samples the p-bit adder outputs after a burn-in window, counts ones per bit and
// majority-decodes the counts into a stable result for direct readback.
module pbit_sample_decoder #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] burn_in,
    input  logic [CNT_W-1:0] steps,
    input  logic [WIDTH-1:0] a_out,
    input  logic [WIDTH-1:0] b_out,
    input  logic [WIDTH-1:0] sum_out,
    input  logic             overflow,
    input  logic [2:0]       count_sel,
    output logic [WIDTH-1:0] result,
    output logic             ovf_result,
    output logic [CNT_W-1:0] count_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {StIdle, StSettle, StAccum, StDecide} state_e;

    state_e           state_q;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] steps_q;
    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] ones_q [WIDTH];
    logic [CNT_W-1:0] ovf_cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             ovf_result_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] bus_sel;
    logic [WIDTH-1:0] decided;
    logic             ovf_decided;

    always_comb begin
        bus_sel = sum_out;
        case (mode_q)
            2'd0:    bus_sel = sum_out;
            2'd1:    bus_sel = a_out;
            default: bus_sel = b_out;
        endcase
    end

    // Strict majority at CNT_W+1 bits so 2*count cannot overflow; a tie decodes to 0.
    always_comb begin
        decided = '0;
        for (int i = 0; i < WIDTH; i++) begin
            decided[i] = {ones_q[i], 1'b0} > {1'b0, steps_q};
        end
        ovf_decided = {ovf_cnt_q, 1'b0} > {1'b0, steps_q};
    end

    always_comb begin
        count_out = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (count_sel == 3'(i)) begin
                count_out = ones_q[i];
            end
        end
        if (count_sel == 3'(WIDTH)) begin
            count_out = ovf_cnt_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            mode_q       <= 2'd0;
            steps_q      <= '0;
            cyc_q        <= '0;
            ovf_cnt_q    <= '0;
            result_q     <= '0;
            ovf_result_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                ones_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    // A start coinciding with the done pulse is dropped; it must be reasserted.
                    if (start && !done_q) begin
                        mode_q    <= mode;
                        steps_q   <= steps;
                        busy_q    <= 1'b1;
                        ovf_cnt_q <= '0;
                        for (int i = 0; i < WIDTH; i++) begin
                            ones_q[i] <= '0;
                        end
                        if (burn_in != '0) begin
                            state_q <= StSettle;
                            cyc_q   <= burn_in;
                        end else if (steps != '0) begin
                            state_q <= StAccum;
                            cyc_q   <= steps;
                        end else begin
                            state_q <= StDecide;
                        end
                    end
                end
                StSettle: begin
                    if (cyc_q == CNT_W'(1)) begin
                        if (steps_q != '0) begin
                            state_q <= StAccum;
                            cyc_q   <= steps_q;
                        end else begin
                            state_q <= StDecide;
                            cyc_q   <= '0;
                        end
                    end else begin
                        cyc_q <= cyc_q - CNT_W'(1);
                    end
                end
                StAccum: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        ones_q[i] <= ones_q[i] + {{(CNT_W - 1){1'b0}}, bus_sel[i]};
                    end
                    ovf_cnt_q <= ovf_cnt_q + {{(CNT_W - 1){1'b0}}, overflow};
                    if (cyc_q == CNT_W'(1)) begin
                        state_q <= StDecide;
                        cyc_q   <= '0;
                    end else begin
                        cyc_q <= cyc_q - CNT_W'(1);
                    end
                end
                StDecide: begin
                    result_q     <= decided;
                    ovf_result_q <= ovf_decided;
                    done_q       <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign result     = result_q;
    assign ovf_result = ovf_result_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_pbit_sample_decoder.sv
// Directed table-driven bench for pbit_sample_decoder plus hand-written corner sequences.
module tb_pbit_sample_decoder;

    localparam int WIDTH = 4;
    localparam int CNT_W = 16;

    logic             clk;
    logic             reset;
    logic             start;
    logic [1:0]       mode;
    logic [CNT_W-1:0] burn_in;
    logic [CNT_W-1:0] steps;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic [WIDTH-1:0] sum_out;
    logic             overflow;
    logic [2:0]       count_sel;
    logic [WIDTH-1:0] result;
    logic             ovf_result;
    logic [CNT_W-1:0] count_out;
    logic             busy;
    logic             done;

    int total = 0;
    int bad   = 0;

    pbit_sample_decoder #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .burn_in   (burn_in),
        .steps     (steps),
        .a_out     (a_out),
        .b_out     (b_out),
        .sum_out   (sum_out),
        .overflow  (overflow),
        .count_sel (count_sel),
        .result    (result),
        .ovf_result(ovf_result),
        .count_out (count_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus index k is the edge number (E0 = start edge) at which a value is sampled.
    typedef struct {
        logic [1:0] mode;
        int burn;
        int steps;
        int a_early;
        int a_late;
        int a_switch;
        int b_val;
        bit b_alt;
        int s_val;
        int ovf_n;
        int restart_k;
        int res;
        int ovf_res;
        int c0;
        int c1;
        int c2;
        int c3;
        int c4;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic drive(input vec_t v, input int k);
        a_out    = (k <= v.a_switch) ? 4'(v.a_early) : 4'(v.a_late);
        b_out    = (v.b_alt && (k % 2 == 0)) ? 4'd0 : 4'(v.b_val);
        sum_out  = 4'(v.s_val);
        overflow = (k <= v.burn + v.ovf_n);
        start    = (k == v.restart_k);
    endtask

    task automatic check_counts(input string tag, input int c0, input int c1, input int c2,
                                input int c3, input int c4);
        int want [5];
        want = '{c0, c1, c2, c3, c4};
        for (int s = 0; s < 5; s++) begin
            count_sel = 3'(s);
            #1;
            check($sformatf("%s count_out sel%0d", tag, s), int'(count_out), want[s]);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int d;
        int first_done;
        int shape_err;
        d = v.burn + v.steps + 1;
        drive(v, 0);
        mode    = v.mode;
        burn_in = CNT_W'(v.burn);
        steps   = CNT_W'(v.steps);
        start   = 1'b1;
        tick();
        // Perturb the latched controls mid-run; the decode must not notice.
        mode       = v.mode ^ 2'd1;
        burn_in    = 16'd3;
        steps      = steps + 16'd7;
        first_done = -1;
        shape_err  = 0;
        for (int k = 1; k <= d + 2; k++) begin
            drive(v, k);
            tick();
            if (done && first_done < 0) first_done = k;
            if (k < d) shape_err += (busy !== 1'b1 || done !== 1'b0) ? 1 : 0;
            else if (k == d) shape_err += (busy !== 1'b0 || done !== 1'b1) ? 1 : 0;
            else shape_err += (busy !== 1'b0 || done !== 1'b0) ? 1 : 0;
        end
        start = 1'b0;
        check($sformatf("v%0d done edge", idx), first_done, d);
        check($sformatf("v%0d busy/done shape errors", idx), shape_err, 0);
        check($sformatf("v%0d result", idx), int'(result), v.res);
        check($sformatf("v%0d ovf_result", idx), int'(ovf_result), v.ovf_res);
        check_counts($sformatf("v%0d", idx), v.c0, v.c1, v.c2, v.c3, v.c4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen_done;
        //           mode burn steps aE aL aSw b alt s ovfn rst res ovf c0  c1  c2 c3  c4
        vecs[0] = '{2'd0, 0, 100, 7, 7, 0, 5, 1'b0, 8, 0, -1, 8, 0, 0, 0, 0, 100, 0};
        vecs[1] = '{2'd2, 0, 100, 15, 15, 0, 9, 1'b1, 15, 0, -1, 0, 0, 50, 0, 0, 50, 0};
        vecs[2] = '{2'd1, 10, 20, 15, 0, 10, 15, 1'b0, 15, 0, -1, 0, 0, 0, 0, 0, 0, 0};
        vecs[3] = '{2'd0, 0, 100, 12, 12, 0, 12, 1'b0, 3, 60, -1, 3, 1, 100, 100, 0, 0, 60};
        vecs[4] = '{2'd0, 5, 0, 15, 15, 0, 15, 1'b0, 15, 0, -1, 0, 0, 0, 0, 0, 0, 0};
        vecs[5] = '{2'd3, 0, 7, 10, 10, 0, 5, 1'b0, 10, 0, -1, 5, 0, 7, 0, 7, 0, 0};
        vecs[6] = '{2'd1, 2, 5, 6, 6, 0, 9, 1'b0, 9, 2, -1, 6, 0, 0, 5, 5, 0, 2};
        vecs[7] = '{2'd0, 0, 100, 0, 0, 0, 0, 1'b0, 8, 60, 50, 8, 1, 0, 0, 0, 100, 60};

        reset     = 1'b1;
        start     = 1'b0;
        mode      = 2'd0;
        burn_in   = '0;
        steps     = '0;
        a_out     = '0;
        b_out     = '0;
        sum_out   = '0;
        overflow  = 1'b0;
        count_sel = 3'd0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("reset result", int'(result), 0);
        check("reset ovf_result", int'(ovf_result), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check_counts("reset", 0, 0, 0, 0, 0);

        for (int i = 0; i < 8; i++) begin
            run_vec(i, vecs[i]);
            tick();
        end

        // Reset in the middle of a run clears everything at once.
        mode     = 2'd0;
        burn_in  = '0;
        steps    = 16'd100;
        sum_out  = 4'd8;
        overflow = 1'b1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        #2;
        reset = 1'b1;
        #1;
        check("midreset busy", int'(busy), 0);
        check("midreset result", int'(result), 0);
        check("midreset ovf_result", int'(ovf_result), 0);
        check("midreset done", int'(done), 0);
        check_counts("midreset", 0, 0, 0, 0, 0);
        tick();
        reset     = 1'b0;
        seen_done = 0;
        for (int k = 0; k < 120; k++) begin
            tick();
            if (done) seen_done++;
        end
        check("midreset no done", seen_done, 0);
        check("midreset stays idle", int'(busy), 0);

        // A start held during the done cycle is dropped and must be reasserted.
        sum_out  = 4'd1;
        overflow = 1'b0;
        steps    = 16'd2;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("short run done", int'(done), 1);
        start = 1'b1;
        tick();
        check("start in done cycle ignored", int'(busy), 0);
        tick();
        check("reasserted start accepted", int'(busy), 1);
        start = 1'b0;
        tick();
        tick();
        tick();
        check("reasserted run done", int'(done), 1);
        check("reasserted run result", int'(result), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
